// File: rtl/cpu_defs.sv
// Shared definitions for the trap sequencer: state encoding,
// exception cause codes and the default handler entry address.
package cpu_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } trap_state_t;

    // Cause codes; only CAUSE_TR is produced today.
    localparam logic [4:0] CAUSE_INT  = 5'd0;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_ADES = 5'd5;
    localparam logic [4:0] CAUSE_SYS  = 5'd8;
    localparam logic [4:0] CAUSE_BP   = 5'd9;
    localparam logic [4:0] CAUSE_RI   = 5'd10;
    localparam logic [4:0] CAUSE_OV   = 5'd12;
    localparam logic [4:0] CAUSE_TR   = 5'd13;

    localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_0180;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clk, reset, inc (count enable), cnt (value, sticks at all-ones).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/ERET sequencer: captures EPC/Cause, flushes younger stages,
// redirects the PC to the handler and back, owns EXL and DropCnt.
// Ports: clk, reset (sync, active-high); TRAP, ERET_id, Stall,
// NextPC_id from ID; Flush_if/id/ex, PC_redirect, RedirectAddr,
// EPC, Cause, EXL, DropCnt (all registered).
module trap_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
    parameter logic [4:0]  TRAP_CAUSE   = CAUSE_TR,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             TRAP,
    input  logic             ERET_id,
    input  logic             Stall,
    input  logic [31:0]      NextPC_id,
    output logic             Flush_if,
    output logic             Flush_id,
    output logic             Flush_ex,
    output logic             PC_redirect,
    output logic [31:0]      RedirectAddr,
    output logic [31:0]      EPC,
    output logic [4:0]       Cause,
    output logic             EXL,
    output logic [CNT_W-1:0] DropCnt
);

    trap_state_t r_state;
    trap_state_t w_next;

    logic        w_take;
    logic        w_ret;
    logic        w_drop;

    logic        w_flush_if;
    logic        w_flush_ex;
    logic        w_redir;
    logic [31:0] w_raddr;

    logic        r_flush_if;
    logic        r_flush_ex;
    logic        r_redir;
    logic [31:0] r_raddr;
    logic [31:0] r_epc;
    logic [4:0]  r_cause;
    logic        r_exl;

    assign w_take = (r_state == ST_IDLE) && TRAP && !Stall;
    assign w_ret  = (r_state == ST_HANDLER) && ERET_id && !Stall;
    // A simultaneous ERET shields the trap from being counted.
    assign w_drop = (r_state == ST_HANDLER) && TRAP && !ERET_id;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_take) w_next = ST_FLUSH;
            ST_FLUSH:   w_next = ST_HANDLER;
            ST_HANDLER: if (w_ret) w_next = ST_RETURN;
            ST_RETURN:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Output decode of the state being entered; registered below so
    // the flush/redirect pulse lines up with the FLUSH/RETURN cycle.
    always_comb begin
        w_flush_if = 1'b0;
        w_flush_ex = 1'b0;
        w_redir    = 1'b0;
        w_raddr    = r_raddr;
        unique case (1'b1)
            w_take: begin
                w_flush_if = 1'b1;
                w_flush_ex = 1'b1;
                w_redir    = 1'b1;
                w_raddr    = HANDLER_ADDR;
            end
            w_ret: begin
                w_flush_if = 1'b1;
                w_redir    = 1'b1;
                w_raddr    = r_epc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_if <= 1'b0;
            r_flush_ex <= 1'b0;
            r_redir    <= 1'b0;
            r_raddr    <= '0;
            r_epc      <= '0;
            r_cause    <= '0;
            r_exl      <= 1'b0;
        end else begin
            r_flush_if <= w_flush_if;
            r_flush_ex <= w_flush_ex;
            r_redir    <= w_redir;
            r_raddr    <= w_raddr;
            if (w_take) begin
                // NextPC_id is PC+4; wraps modulo 2^32.
                r_epc   <= NextPC_id - 32'd4;
                r_cause <= TRAP_CAUSE;
                r_exl   <= 1'b1;
            end else if (w_ret) begin
                r_exl   <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_drop),
        .cnt  (DropCnt)
    );

    assign Flush_if     = r_flush_if;
    assign Flush_id     = r_flush_if;
    assign Flush_ex     = r_flush_ex;
    assign PC_redirect  = r_redir;
    assign RedirectAddr = r_raddr;
    assign EPC          = r_epc;
    assign Cause        = r_cause;
    assign EXL          = r_exl;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_trap_ctrl;

    logic        clk;
    logic        reset;
    logic        TRAP;
    logic        ERET_id;
    logic        Stall;
    logic [31:0] NextPC_id;
    logic        Flush_if;
    logic        Flush_id;
    logic        Flush_ex;
    logic        PC_redirect;
    logic [31:0] RedirectAddr;
    logic [31:0] EPC;
    logic [4:0]  Cause;
    logic        EXL;
    logic [7:0]  DropCnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    trap_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .TRAP        (TRAP),
        .ERET_id     (ERET_id),
        .Stall       (Stall),
        .NextPC_id   (NextPC_id),
        .Flush_if    (Flush_if),
        .Flush_id    (Flush_id),
        .Flush_ex    (Flush_ex),
        .PC_redirect (PC_redirect),
        .RedirectAddr(RedirectAddr),
        .EPC         (EPC),
        .Cause       (Cause),
        .EXL         (EXL),
        .DropCnt     (DropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: "in handler" is EXL without a pending flush
    // pulse; "idle" is EXL clear with no return pulse in progress.
    bit          m_flush;
    bit          m_ret;
    bit          m_exl;
    logic [31:0] m_epc;
    logic [4:0]  m_cause;
    logic [31:0] m_raddr;
    int          m_drop;

    initial begin
        m_flush = 0; m_ret = 0; m_exl = 0;
        m_epc = 0; m_cause = 0; m_raddr = 0; m_drop = 0;
    end

    always @(posedge clk) begin
        bit idle, hnd, nf, nr;
        if (reset) begin
            m_flush = 0; m_ret = 0; m_exl = 0;
            m_epc = 0; m_cause = 0; m_raddr = 0; m_drop = 0;
        end else begin
            idle = !m_exl && !m_ret;
            hnd  = m_exl && !m_flush;
            nf   = idle && TRAP && !Stall;
            nr   = hnd && ERET_id && !Stall;
            if (hnd && TRAP && !ERET_id && m_drop < 255) m_drop++;
            if (nf) begin
                m_epc   = NextPC_id - 32'd4;
                m_cause = 5'd13;
                m_exl   = 1;
                m_raddr = 32'h180;
            end
            if (nr) begin
                m_exl   = 0;
                m_raddr = m_epc;
            end
            m_flush = nf;
            m_ret   = nr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_flush_if", 32'(Flush_if), 32'(m_flush | m_ret));
            chk("m_flush_id", 32'(Flush_id), 32'(m_flush | m_ret));
            chk("m_flush_ex", 32'(Flush_ex), 32'(m_flush));
            chk("m_redir", 32'(PC_redirect), 32'(m_flush | m_ret));
            chk("m_raddr", RedirectAddr, m_raddr);
            chk("m_epc", EPC, m_epc);
            chk("m_cause", 32'(Cause), 32'(m_cause));
            chk("m_exl", 32'(EXL), 32'(m_exl));
            chk("m_drop", 32'(DropCnt), 32'(m_drop));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_fif"}, 32'(Flush_if), 32'd0);
        chk({tag, "_fex"}, 32'(Flush_ex), 32'd0);
        chk({tag, "_redir"}, 32'(PC_redirect), 32'd0);
    endtask

    initial begin
        reset = 1; TRAP = 0; ERET_id = 0; Stall = 0; NextPC_id = 0;
        cyc();
        chk_en = 1;
        cyc();
        reset = 0;
        repeat (5) cyc();
        chk_quiet("rst");
        chk("rst_raddr", RedirectAddr, 32'h0);
        chk("rst_epc", EPC, 32'h0);
        chk("rst_exl", 32'(EXL), 32'h0);
        chk("rst_drop", 32'(DropCnt), 32'h0);

        TRAP = 1; NextPC_id = 32'h0040_0010;
        cyc();
        TRAP = 0;
        chk("trap_fif", 32'(Flush_if), 32'd1);
        chk("trap_fid", 32'(Flush_id), 32'd1);
        chk("trap_fex", 32'(Flush_ex), 32'd1);
        chk("trap_redir", 32'(PC_redirect), 32'd1);
        chk("trap_raddr", RedirectAddr, 32'h180);
        chk("trap_epc", EPC, 32'h0040_000C);
        chk("trap_cause", 32'(Cause), 32'd13);
        chk("trap_exl", 32'(EXL), 32'd1);
        cyc();
        chk_quiet("trap_t2");

        TRAP = 1;
        for (int i = 0; i < 300; i++) begin
            Stall = 1'($urandom_range(0, 1));
            cyc();
        end
        TRAP = 0; Stall = 0;
        cyc();
        chk("sat_drop", 32'(DropCnt), 32'd255);
        chk("sat_epc", EPC, 32'h0040_000C);
        chk("sat_cause", 32'(Cause), 32'd13);
        chk_quiet("sat");

        ERET_id = 1;
        cyc();
        ERET_id = 0;
        chk("eret_fif", 32'(Flush_if), 32'd1);
        chk("eret_fid", 32'(Flush_id), 32'd1);
        chk("eret_fex", 32'(Flush_ex), 32'd0);
        chk("eret_raddr", RedirectAddr, 32'h0040_000C);
        chk("eret_exl", 32'(EXL), 32'd0);
        cyc();
        chk_quiet("eret_t2");

        TRAP = 1; NextPC_id = 32'h0;
        cyc();
        TRAP = 0;
        chk("wrap_epc", EPC, 32'hFFFF_FFFC);
        chk("wrap_fex", 32'(Flush_ex), 32'd1);
        cyc();
        ERET_id = 1;
        cyc();
        ERET_id = 0;
        cyc();

        TRAP = 1; Stall = 1; NextPC_id = 32'h0000_1000;
        cyc();
        chk_quiet("stall1");
        cyc();
        chk_quiet("stall2");
        Stall = 0;
        cyc();
        TRAP = 0;
        chk("stall_fex", 32'(Flush_ex), 32'd1);
        chk("stall_epc", EPC, 32'h0000_0FFC);
        cyc();
        ERET_id = 1;
        cyc();
        ERET_id = 0;
        cyc();

        TRAP = 1;
        cyc();
        TRAP = 0;
        chk("pre_rst_fex", 32'(Flush_ex), 32'd1);
        reset = 1;
        cyc();
        reset = 0;
        chk_quiet("midrst");
        chk("midrst_exl", 32'(EXL), 32'd0);
        chk("midrst_drop", 32'(DropCnt), 32'd0);
        chk("midrst_epc", EPC, 32'd0);
        ERET_id = 1;
        cyc();
        ERET_id = 0;
        chk_quiet("midrst_eret");

        for (int i = 0; i < 3000; i++) begin
            TRAP      = ($urandom_range(0, 3) == 0);
            ERET_id   = ($urandom_range(0, 4) == 0);
            Stall     = ($urandom_range(0, 3) == 0);
            NextPC_id = $urandom;
            reset     = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 0; TRAP = 0; ERET_id = 0; Stall = 0;
        cyc();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap/exception sequencer for the 5-stage MIPS pipeline. It accepts the combinational TRAP condition from the decode stage and captures the EPC and cause. It then flushes the younger pipeline stages and redirects the PC to the handler. On ERET it redirects back to EPC. It also owns the EXL (exception-level) bit and a saturating counter of traps dropped while EXL is set.

Parameters:
HANDLER_ADDR, 32'h0000_0180, trap handler entry address
TRAP_CAUSE, 5'd13, cause code written on a trap (MIPS "Tr")
CNT_W, 8, width of the dropped-trap counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
TRAP  input  1  trap condition of the instruction currently in ID (from ID stage)
ERET_id  input  1  ERET decoded in ID
Stall  input  1  load-use stall from the ID hazard detector
NextPC_id  input  32  PC+4 of the instruction in ID
Flush_if  output  1  kill IF/ID register contents (insert bubble)
Flush_id  output  1  kill ID/EX register contents
Flush_ex  output  1  kill EX/MEM register contents
PC_redirect  output  1  PC mux select: load RedirectAddr
RedirectAddr  output  32  redirect target
EPC  output  32  exception PC
Cause  output  5  last exception cause
EXL  output  1  exception level; 1 while in the handler
DropCnt  output  CNT_W  saturating count of traps ignored while EXL=1

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset is synchronous and active-high. It has priority over all other inputs, including mid-flush or mid-return.
  - On reset: state=IDLE; Flush_*=0; PC_redirect=0; RedirectAddr=0; EPC=0; Cause=0; EXL=0; DropCnt=0.
- All outputs are registered. Decision cycle T, effect cycle T+1. At T+1 the trapping instruction has advanced to EX.
- States:
  - IDLE
  - FLUSH: one cycle
  - HANDLER
  - RETURN: one cycle
- IDLE:
  - If TRAP && !Stall at T: EPC<=NextPC_id-32'd4, Cause<=TRAP_CAUSE, EXL<=1, and go to FLUSH.
  - TRAP && Stall: no action. TRAP is re-evaluated on the next, non-stalled cycle.
  - ERET_id in IDLE is ignored: no redirect, no state change.
  - If TRAP and ERET_id are both asserted, TRAP wins.
- FLUSH (exactly 1 cycle):
  - Flush_if=Flush_id=Flush_ex=1. This kills the trapping instruction in EX and its two successors.
  - PC_redirect=1, RedirectAddr=HANDLER_ADDR.
  - Next state is HANDLER.
  - Flush overrides Stall downstream; Stall is don't-care in this cycle.
- HANDLER:
  - All flush and redirect outputs are 0.
  - ERET_id && !Stall: go to RETURN.
  - TRAP (any Stall): not taken. DropCnt increments and saturates at all-ones; EPC and Cause are unchanged.
  - If TRAP and ERET_id are both asserted, ERET wins and DropCnt is not incremented.
- RETURN (exactly 1 cycle):
  - Flush_if=Flush_id=1, Flush_ex=0. ERET itself completes as a no-op.
  - PC_redirect=1, RedirectAddr=EPC.
  - EXL<=0. Next state is IDLE.
  - A TRAP seen during RETURN is ignored and not counted.
- Outside FLUSH and RETURN: RedirectAddr holds its last value; only PC_redirect qualifies it.
- Arithmetic:
  - EPC subtraction is 32-bit modulo. NextPC_id=0 gives EPC=32'hFFFF_FFFC.
  - DropCnt never wraps.
- Latency:
  - Trap detect to handler fetch: 1 cycle of redirect; the handler instruction is in IF at T+2.
  - ERET to EPC refetch: likewise.

Decomposition:
- Shared package (cpu_defs):
  - state encoding (IDLE=2'd0, FLUSH=2'd1, HANDLER=2'd2, RETURN=2'd3)
  - cause codes (TRAP_CAUSE and reserved future codes)
  - default HANDLER_ADDR
- One sub-module: sat_counter (parameter W; inputs clk, reset, inc; output cnt; saturates at 2^W-1), used for DropCnt.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, EXL=0, state IDLE.
- TRAP=1 with NextPC_id=32'h0040_0010, Stall=0 at T:
  - T+1: Flush_if/id/ex=1, PC_redirect=1, RedirectAddr=32'h180, EPC=32'h0040_000C, Cause=13, EXL=1.
  - T+2: all flush and redirect outputs 0.
- TRAP=1 with Stall=1 for 2 cycles, then Stall=0 -> no flush during the stall; the flush fires exactly 1 cycle after the first non-stalled TRAP cycle.
- In HANDLER, pulse TRAP 300 times (CNT_W=8) -> DropCnt=255 and holds; EPC and Cause unchanged; no redirect.
- In HANDLER, ERET_id=1 with Stall=0 -> next cycle Flush_if=Flush_id=1, Flush_ex=0, RedirectAddr=EPC, EXL=0; following cycle IDLE. A new TRAP is then taken normally.
- reset asserted during the FLUSH cycle -> next cycle all outputs 0, EXL=0, DropCnt=0, state IDLE; ERET_id afterwards is ignored.
